// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request handshake and 64-bit memory bus between CPU-side control and the load/store unit
interface load_store_unit_if;
   logic        start, is_store, unsigned_ld, busy, done, misaligned, mem_wr;
   logic [1:0]  size;
   logic [63:0] addr, store_data, load_data, mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   modport master (
      output start, is_store, size, unsigned_ld, addr, store_data, mem_rdata,
      input  busy, done, misaligned, load_data, mem_raddr, mem_waddr, mem_wdata, mem_wr
   );
   modport slave (
      input  start, is_store, size, unsigned_ld, addr, store_data, mem_rdata,
      output busy, done, misaligned, load_data, mem_raddr, mem_waddr, mem_wdata, mem_wr
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle byte/half/word/doubleword load/store over a doubleword-addressed 64-bit memory
module load_store_unit (
   input logic clk,
   input logic reset,
   load_store_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;
   state_t      state_q, state_d;
   logic [63:0] addr_q, addr_d, sdata_q, sdata_d, wbuf_q, wbuf_d, load_q, load_d;
   logic [1:0]  size_q, size_d;
   logic        is_store_q, is_store_d, unsigned_q, unsigned_d, mis_q, mis_d;
   logic        mis_in;
   logic [5:0]  sh;
   logic [63:0] field, mask;
   assign mis_in = bus.size == 2'd1 ? bus.addr[0] :
                   bus.size == 2'd2 ? |bus.addr[1:0] :
                   bus.size == 2'd3 ? |bus.addr[2:0] : 1'b0;
   assign sh    = {addr_q[2:0], 3'b000};
   assign field = bus.mem_rdata >> sh;
   assign mask  = (size_q == 2'd0 ? 64'hFF : size_q == 2'd1 ? 64'hFFFF : 64'hFFFF_FFFF) << sh;
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      is_store_d = is_store_q;
      unsigned_d = unsigned_q;
      sdata_d    = sdata_q;
      wbuf_d     = wbuf_q;
      load_d     = load_q;
      mis_d      = mis_q;
      case (state_q)
         IDLE: if (bus.start) begin
            addr_d     = bus.addr;
            size_d     = bus.size;
            is_store_d = bus.is_store;
            unsigned_d = bus.unsigned_ld;
            sdata_d    = bus.store_data;
            mis_d      = mis_in;
            state_d    = mis_in ? DONE : (bus.is_store && bus.size == 2'd3) ? WRITE : READ;
         end
         READ:  state_d = LATCH;
         LATCH: begin
            state_d = is_store_q ? WRITE : DONE;
            if (is_store_q)
               wbuf_d = (bus.mem_rdata & ~mask) | ((sdata_q << sh) & mask);
            else
               load_d = size_q == 2'd0 ? {{56{~unsigned_q & field[7]}}, field[7:0]} :
                        size_q == 2'd1 ? {{48{~unsigned_q & field[15]}}, field[15:0]} :
                        size_q == 2'd2 ? {{32{~unsigned_q & field[31]}}, field[31:0]} : field;
         end
         WRITE:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         is_store_q <= 1'b0;
         unsigned_q <= 1'b0;
         sdata_q    <= '0;
         wbuf_q     <= '0;
         load_q     <= '0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         is_store_q <= is_store_d;
         unsigned_q <= unsigned_d;
         sdata_q    <= sdata_d;
         wbuf_q     <= wbuf_d;
         load_q     <= load_d;
         mis_q      <= mis_d;
      end
   end
   assign bus.busy       = state_q != IDLE;
   assign bus.done       = state_q == DONE;
   assign bus.misaligned = mis_q;
   assign bus.load_data  = load_q;
   assign bus.mem_raddr  = {addr_q[63:3], 3'b000};
   assign bus.mem_waddr  = {addr_q[63:3], 3'b000};
   assign bus.mem_wdata  = size_q == 2'd3 ? sdata_q : wbuf_q;
   assign bus.mem_wr     = state_q == WRITE && !reset;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit against a small 64-bit memory model
module tb_load_store_unit;
   typedef struct {
      string       tag;
      int          lat;
      logic [63:0] ld;
      logic        mis;
      int          wr_at;
      logic [63:0] wd;
   } exp_t;
   localparam logic [63:0] W100 = 64'h8877_6655_4433_2211;
   localparam logic [63:0] W100_SH = 64'h8877_6655_BEEF_2211;
   localparam logic [63:0] W108 = 64'h0123_4567_89AB_CDEF;
   logic clk = 1'b0, reset = 1'b1, init = 1'b1;
   logic [63:0] mem [0:63];
   int checks = 0, errors = 0;
   exp_t exp_q[$];
   exp_t e;
   logic [63:0] acc;
   load_store_unit_if bus ();
   load_store_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
         mem[32] <= W100;
      end else if (bus.mem_wr)
         mem[bus.mem_waddr[8:3]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_raddr[8:3]];
   end
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask
   task automatic req(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                      input logic [63:0] a, input logic [63:0] sd, input int lat,
                      input logic [63:0] ld, input logic mis, input int wr_at, input logic [63:0] wd);
      int n, wr_n, wr_cyc;
      logic [63:0] wdata_s, waddr_s;
      exp_t x;
      bus.start = 1'b1;
      bus.is_store = st;
      bus.size = sz;
      bus.unsigned_ld = uns;
      bus.addr = a;
      bus.store_data = sd;
      exp_q.push_back('{tag, lat, ld, mis, wr_at, wd});
      n = 0;
      wr_n = 0;
      wr_cyc = 0;
      wdata_s = '0;
      waddr_s = '0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) bus.start = 1'b0;
         if (bus.mem_wr) begin
            wr_n++;
            wr_cyc = n;
            wdata_s = bus.mem_wdata;
            waddr_s = bus.mem_waddr;
         end
      end while (!bus.done && n < 10);
      x = exp_q.pop_front();
      chk({x.tag, " done"}, 64'(bus.done), 64'd1);
      chk({x.tag, " latency"}, 64'(n), 64'(x.lat));
      chk({x.tag, " load_data"}, bus.load_data, x.ld);
      chk({x.tag, " misaligned"}, 64'(bus.misaligned), 64'(x.mis));
      chk({x.tag, " wr count"}, 64'(wr_n), 64'(x.wr_at != 0));
      if (x.wr_at != 0) begin
         chk({x.tag, " wr cycle"}, 64'(wr_cyc), 64'(x.wr_at));
         chk({x.tag, " wdata"}, wdata_s, x.wd);
         chk({x.tag, " waddr"}, waddr_s, {a[63:3], 3'b000});
      end
      @(posedge clk);
      #1;
      chk({x.tag, " idle after done"}, {62'd0, bus.busy, bus.done}, 64'd0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.is_store = 1'b0;
      bus.size = 2'd0;
      bus.unsigned_ld = 1'b0;
      bus.addr = '0;
      bus.store_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      init = 1'b0;
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst done", 64'(bus.done), 64'd0);
      chk("rst misaligned", 64'(bus.misaligned), 64'd0);
      chk("rst load_data", bus.load_data, 64'd0);
      chk("rst mem_wr", 64'(bus.mem_wr), 64'd0);
      chk("rst mem_wdata", bus.mem_wdata, 64'd0);
      chk("rst mem_raddr", bus.mem_raddr, 64'd0);
      chk("rst mem_waddr", bus.mem_waddr, 64'd0);
      req("lb", 1'b0, 2'd0, 1'b0, 64'h107, '0, 3, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 0, '0);
      req("lbu", 1'b0, 2'd0, 1'b1, 64'h107, '0, 3, 64'h88, 1'b0, 0, '0);
      req("lh", 1'b0, 2'd1, 1'b0, 64'h104, '0, 3, 64'h6655, 1'b0, 0, '0);
      req("sh", 1'b1, 2'd1, 1'b0, 64'h102, 64'h1234_5678_9ABC_BEEF, 4, 64'h6655, 1'b0, 3, W100_SH);
      chk("sh mem", mem[32], W100_SH);
      req("sd", 1'b1, 2'd3, 1'b0, 64'h108, W108, 2, 64'h6655, 1'b0, 1, W108);
      chk("sd mem", mem[33], W108);
      req("ld", 1'b0, 2'd3, 1'b0, 64'h108, '0, 3, W108, 1'b0, 0, '0);
      req("lw mis", 1'b0, 2'd2, 1'b0, 64'h102, '0, 1, W108, 1'b1, 0, '0);
      req("lw", 1'b0, 2'd2, 1'b0, 64'h104, '0, 3, 64'hFFFF_FFFF_8877_6655, 1'b0, 0, '0);
      bus.start = 1'b1;
      bus.is_store = 1'b1;
      bus.size = 2'd0;
      bus.addr = 64'h100;
      bus.store_data = 64'hAA;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("sb busy", 64'(bus.busy), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("sb wr before reset", 64'(bus.mem_wr), 64'd1);
      reset = 1'b1;
      #1;
      chk("sb wr under reset", 64'(bus.mem_wr), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("sb rst busy", 64'(bus.busy), 64'd0);
      chk("sb rst done", 64'(bus.done), 64'd0);
      chk("sb rst misaligned", 64'(bus.misaligned), 64'd0);
      chk("sb rst load_data", bus.load_data, 64'd0);
      chk("sb rst mem_wr", 64'(bus.mem_wr), 64'd0);
      chk("sb rst mem_wdata", bus.mem_wdata, 64'd0);
      chk("sb rst mem_raddr", bus.mem_raddr, 64'd0);
      chk("sb mem unchanged", mem[32], W100_SH);
      @(posedge clk);
      #1;
      chk("sb no done", 64'(bus.done), 64'd0);
      bus.is_store = 1'b0;
      bus.size = 2'd3;
      bus.unsigned_ld = 1'b0;
      acc = '0;
      for (int k = 0; k < 12; k++) begin
         bus.start = 1'b1;
         bus.addr = (k % 3 == 0) ? 64'h108 : 64'h100;
         if (k % 4 == 0) begin
            acc = bus.addr;
            exp_q.push_back('{"b2b", 0, (acc == 64'h108) ? W108 : W100_SH, 1'b0, 0, 64'd0});
         end
         @(posedge clk);
         #1;
         chk("b2b raddr", bus.mem_raddr, acc);
         chk("b2b done", 64'(bus.done), 64'(k % 4 == 2));
         if (bus.done && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("b2b load_data", bus.load_data, e.ld);
         end
      end
      bus.start = 1'b0;
      chk("b2b drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store unit between the CPU datapath and the 64-bit data memory (`Memoria64`).
- Takes one memory request per handshake.
- Performs byte/half/word/doubleword accesses on a doubleword-wide, doubleword-addressed memory.
- Narrow stores use read-modify-write.
- Narrow loads are sign- or zero-extended.
- The control FSM issues `start` and waits for `done` before writeback to MDR/register file.

## Interface

Parameters: none; data width fixed at 64, address width fixed at 64.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 doubleword
- unsigned_ld  in  1  1 = zero-extend narrow load, 0 = sign-extend
- addr  in  64  byte address
- store_data  in  64  store operand; low bytes used for narrow stores
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  last accepted request was misaligned
- load_data  out  64  extended load result
- mem_raddr  out  64  memory read address, {addr_q[63:3],3'b000}
- mem_waddr  out  64  memory write address, same value as mem_raddr
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data; valid one cycle after mem_raddr is presented
- mem_wr  out  1  memory write enable

## Operation

Request capture:
- On start in IDLE, latch into internal registers: addr_q, size_q, is_store_q, unsigned_q, sdata_q.
- Lane offset off = addr_q[2:0]; memory layout is little-endian; byte k of the word is bits [8k+7:8k].

Alignment check (at accept):
- Misaligned if addr mod 2^size != 0, i.e. half with addr[0]=1, word with addr[1:0]!=0, doubleword with addr[2:0]!=0.
- Misaligned requests go IDLE -> DONE.
- No read, no write; misaligned=1; load_data unchanged.

States:
- IDLE: waiting for start.
- READ: mem_raddr presented.
- LATCH: mem_rdata valid.
  - Load: load_data <= extracted field, extended to 64 bits.
  - Narrow store: wbuf <= mem_rdata with bytes [off .. off+2^size-1] replaced by sdata_q low bytes.
- WRITE: mem_wr=1; mem_wdata = wbuf for narrow stores, sdata_q for doubleword stores.
- DONE: done=1, then return to IDLE.

Transitions:
- Load: IDLE -> READ -> LATCH -> DONE.
- Store size 11: IDLE -> WRITE -> DONE. No read is performed.
- Store size 00/01/10: IDLE -> READ -> LATCH -> WRITE -> DONE.
- Misaligned (load or store): IDLE -> DONE.

Output holding:
- misaligned is registered at accept and held until the next accepted start.
- load_data holds its value until the next successful load.
- mem_raddr/mem_waddr are driven from addr_q at all times; they are 0 after reset.
- mem_wr is asserted only in WRITE; it is decoded from state.

## Timing

Start accepted in cycle T (IDLE, start=1):
- Load: READ T+1, LATCH T+2, done and valid load_data in T+3.
- Doubleword store: mem_wr in T+1, done in T+2.
- Narrow store: READ T+1, LATCH T+2, mem_wr in T+3, done in T+4.
- Misaligned: done and misaligned=1 in T+1.

Handshake rules:
- start is ignored in every state other than IDLE, including DONE.
- Earliest next accept is the cycle after DONE.
- mem_wr is high for exactly one cycle per store, and never for loads or misaligned requests.

Reset:
- Reset values: state IDLE; busy=0, done=0, misaligned=0, load_data=0, mem_wr=0, mem_wdata=0; addr_q=0, hence mem_raddr=0 and mem_waddr=0.
- Reset mid-operation aborts the request; no done is produced.
- mem_wr = (state==WRITE) & ~reset, so a reset landing in WRITE suppresses the write.
- reset has priority over start in the same cycle.

## Test plan

Preload the memory word at 0x100 = 0x8877_6655_4433_2211.

1. Narrow loads from 0x107:
   - lb signed -> load_data 0xFFFF_FFFF_FFFF_FF88, done at T+3.
   - lbu -> 0x0000_0000_0000_0088.
   - lh signed from 0x104 -> 0x0000_0000_0000_6655.
2. sh store_data 0x...BEEF at 0x102:
   - One read at T+1.
   - mem_wr only at T+3 with mem_wdata 0x8877_6655_BEEF_2211.
   - done at T+4.
3. sd 0x0123_4567_89AB_CDEF at 0x108:
   - mem_wr at T+1, mem_waddr 0x108, done at T+2.
   - No READ state visited.
   - Subsequent ld at 0x108 returns the same value.
4. lw at 0x102:
   - done and misaligned=1 at T+1, mem_wr never asserted.
   - load_data keeps its previous value.
   - A following aligned lw clears misaligned.
5. sb at 0x100 with reset asserted in the WRITE cycle (T+3):
   - mem_wr stays 0; memory word unchanged.
   - busy=0, done=0, all outputs at reset values next cycle.
6. start held high continuously with back-to-back loads:
   - Requests accepted only in IDLE cycles (every 4 cycles).
   - start pulses during READ/LATCH/DONE have no effect; latched addr_q is unchanged by them.
